// File: rtl/compare_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state encoding,
// result codes ({gt,eq,lt}) and the one-hot verdict check.
package compare_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == RES_GT) || (v == RES_EQ) || (v == RES_LT);
  endfunction

endpackage

// File: rtl/compare.sv
// 1-bit compare cell: one-hot verdict for a single bit pair of A and B.
module compare (
  input  logic a_i,
  input  logic b_i,
  output logic f1_o,
  output logic f2_o,
  output logic f3_o
);

  assign f1_o = a_i & ~b_i;
  assign f2_o = ~(a_i ^ b_i);
  assign f3_o = ~a_i & b_i;

endmodule

// File: rtl/serial_mag_compare.sv
// Accumulates MSB-first per-bit verdicts from the compare cell into a
// WIDTH-bit magnitude result, with a one-cycle done pulse and sticky error.
//
// state  | meaning
// IDLE   | waiting for start; last result, err and bit_cnt held
// RUN    | accepting bit verdicts; busy=1
// DONE   | WIDTH bits accepted; done=1 for exactly one cycle
module serial_mag_compare
  import compare_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          bit_valid,
  input  logic          f_gt,
  input  logic          f_eq,
  input  logic          f_lt,
  output logic          busy,
  output logic          done,
  output logic          res_gt,
  output logic          res_eq,
  output logic          res_lt,
  output logic          err,
  output logic [CW-1:0] bit_cnt
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    res_q, res_d;
  logic          err_q, err_d;
  logic          busy_q, done_q;
  logic [2:0]    verdict;

  assign verdict = {f_gt, f_eq, f_lt};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          res_d   = RES_EQ;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        // a start in RUN wins over a coincident bit_valid: the bit is dropped
        if (start) begin
          cnt_d = '0;
          res_d = RES_EQ;
          err_d = 1'b0;
        end else if (bit_valid) begin
          cnt_d = cnt_q + CW'(1);
          if (!is_onehot3(verdict)) begin
            err_d = 1'b1;
          end else if (res_q == RES_EQ) begin
            res_d = verdict;
          end
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          res_d   = RES_EQ;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= RES_NONE;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign res_gt  = res_q[2];
  assign res_eq  = res_q[1];
  assign res_lt  = res_q[0];
  assign err     = err_q;
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Bench: compare cell feeding serial_mag_compare (WIDTH=8), plus a WIDTH=1
// instance; table-driven operand vectors, a result scoreboard and hand sequences.
module tb_serial_mag_compare;
  import compare_pkg::*;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] mask;
    int         gap;
    logic [2:0] exp_res;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [2:0] res;
    logic       err;
    logic [3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, bit_valid;
  logic a_b, b_b, frc;
  logic c_gt, c_eq, c_lt;
  logic f_gt, f_eq, f_lt;
  logic busy, done, res_gt, res_eq, res_lt, err;
  logic [3:0] bit_cnt;
  logic busy1, done1, gt1, eq1, lt1, err1;
  logic [0:0] cnt1;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  compare u_cell (.a_i(a_b), .b_i(b_b), .f1_o(c_gt), .f2_o(c_eq), .f3_o(c_lt));

  // forced verdict is the illegal gt+lt combination
  assign f_gt = frc ? 1'b1 : c_gt;
  assign f_eq = frc ? 1'b0 : c_eq;
  assign f_lt = frc ? 1'b1 : c_lt;

  serial_mag_compare #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .f_gt(f_gt), .f_eq(f_eq), .f_lt(f_lt),
    .busy(busy), .done(done), .res_gt(res_gt), .res_eq(res_eq), .res_lt(res_lt),
    .err(err), .bit_cnt(bit_cnt)
  );

  serial_mag_compare #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .f_gt(f_gt), .f_eq(f_eq), .f_lt(f_lt),
    .busy(busy1), .done(done1), .res_gt(gt1), .res_eq(eq1), .res_lt(lt1),
    .err(err1), .bit_cnt(cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_res(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] mask);
    logic [7:0] ma, mb;
    ma = a & ~mask;
    mb = b & ~mask;
    if (ma > mb) return RES_GT;
    if (ma == mb) return RES_EQ;
    return RES_LT;
  endfunction

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] mask, input int gap);
    vec_t v;
    v.a = a; v.b = b; v.mask = mask; v.gap = gap;
    v.exp_res = model_res(a, b, mask);
    v.exp_err = (mask != 8'h00);
    return v;
  endfunction

  task automatic feed_bit(input logic a, input logic b, input logic f);
    a_b = a; b_b = b; frc = f; bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0; frc = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    exp_t e;
    exp_t got;
    int n;
    e.res = v.exp_res; e.err = v.exp_err; e.cnt = 4'd8;
    sb.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, "_start_busy"}, busy, 1);
    for (int i = 7; i >= 0; i--) begin
      for (int g = 0; g < v.gap; g++) begin
        bit_valid = 1'b0;
        tick();
        chk({nm, "_gap_busy"}, busy, 1);
        chk({nm, "_gap_cnt"}, bit_cnt, 7 - i);
        chk({nm, "_gap_nodone"}, done, 0);
      end
      feed_bit(v.a[i], v.b[i], v.mask[i]);
      if (i > 0) chk({nm, "_mid_nodone"}, done, 0);
    end
    n = 0;
    while (!done && n < 4) begin
      tick();
      n++;
    end
    chk({nm, "_done_latency"}, n, 0);
    if (!done) begin
      $display("FAIL %s_timeout: got no done expected done within 4 cycles", nm);
      failures++;
      checks++;
    end
    got = sb.pop_front();
    chk({nm, "_res"}, {res_gt, res_eq, res_lt}, got.res);
    chk({nm, "_err"}, err, got.err);
    chk({nm, "_cnt"}, bit_cnt, got.cnt);
    chk({nm, "_done_busy"}, busy, 0);
    tick();
    chk({nm, "_pulse_len"}, done, 0);
    chk({nm, "_hold_res"}, {res_gt, res_eq, res_lt}, got.res);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_b = 1'b0; b_b = 1'b0; frc = 1'b0;
    vecs[0] = mk(8'hA5, 8'hA3, 8'h00, 0);
    vecs[1] = mk(8'h3C, 8'h3C, 8'h00, 0);
    vecs[2] = mk(8'h00, 8'h80, 8'h00, 0);
    vecs[3] = mk(8'hA5, 8'hA3, 8'h00, 3);
    vecs[4] = mk(8'h3C, 8'h3C, 8'h20, 0);
    vecs[5] = mk(8'h5A, 8'h5B, 8'h00, 1);
    vecs[6] = mk(8'h7F, 8'h80, 8'h00, 0);
    vecs[7] = mk(8'h80, 8'h00, 8'h80, 0);
    vecs[8] = mk(8'h80, 8'h00, 8'h01, 2);

    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", {res_gt, res_eq, res_lt}, RES_NONE);
    chk("rst_err", err, 0);
    chk("rst_cnt", bit_cnt, 0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 9; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // equal result holds through a long idle stretch
    run_vec(vecs[1], "hold");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_idle_res", {res_gt, res_eq, res_lt}, RES_EQ);
      chk("hold_idle_cnt", bit_cnt, 8);
    end

    // LT decided on the first bit and never revisited
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      feed_bit(1'b0, (i == 7), 1'b0);
      chk("lt_early_res", {res_gt, res_eq, res_lt}, RES_LT);
      chk("lt_early_cnt", bit_cnt, 8 - i);
    end
    chk("lt_early_done", done, 1);
    tick();

    // err from the previous forced run is cleared by start
    run_vec(vecs[4], "errv");
    chk("err_sticky_idle", err, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("err_cleared", err, 0);
    chk("err_clear_res", {res_gt, res_eq, res_lt}, RES_EQ);

    // restart mid-run with a coincident bit_valid that must be dropped
    for (int i = 7; i >= 4; i--) feed_bit(vecs[0].a[i], vecs[0].b[i], 1'b0);
    chk("abort_pre_cnt", bit_cnt, 4);
    start = 1'b1; bit_valid = 1'b1; a_b = 1'b1; b_b = 1'b0;
    tick();
    start = 1'b0; bit_valid = 1'b0;
    chk("abort_cnt", bit_cnt, 0);
    chk("abort_res", {res_gt, res_eq, res_lt}, RES_EQ);
    chk("abort_busy", busy, 1);
    for (int i = 7; i >= 1; i--) begin
      feed_bit(vecs[0].a[i], vecs[0].b[i], 1'b0);
      chk("abort_nodone", done, 0);
    end
    feed_bit(vecs[0].a[0], vecs[0].b[0], 1'b0);
    chk("abort_done", done, 1);
    chk("abort_final", {res_gt, res_eq, res_lt}, RES_GT);

    // start during the DONE cycle goes straight back to RUN
    start = 1'b1; tick(); start = 1'b0;
    chk("done_start_busy", busy, 1);
    chk("done_start_done", done, 0);
    chk("done_start_cnt", bit_cnt, 0);
    chk("done_start_res", {res_gt, res_eq, res_lt}, RES_EQ);

    // reset after 5 bits: all zero, no done pulse afterwards
    for (int i = 7; i >= 3; i--) feed_bit(vecs[0].a[i], vecs[0].b[i], 1'b0);
    chk("rst_mid_pre_cnt", bit_cnt, 5);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_res", {res_gt, res_eq, res_lt}, RES_NONE);
    chk("rst_mid_cnt", bit_cnt, 0);
    chk("rst_mid_err", err, 0);
    for (int i = 0; i < 4; i++) begin
      feed_bit(1'b1, 1'b0, 1'b0);
      chk("rst_mid_nodone", done, 0);
      chk("rst_mid_idle_cnt", bit_cnt, 0);
    end

    // bit_valid with start in IDLE is ignored
    start = 1'b1; bit_valid = 1'b1; a_b = 1'b0; b_b = 1'b1;
    tick();
    start = 1'b0; bit_valid = 1'b0;
    chk("idle_start_cnt", bit_cnt, 0);
    chk("idle_start_res", {res_gt, res_eq, res_lt}, RES_EQ);

    // WIDTH=1 instance completes after its first accepted bit
    chk("w1_busy", busy1, 1);
    feed_bit(1'b1, 1'b0, 1'b0);
    chk("w1_done", done1, 1);
    chk("w1_res", {gt1, eq1, lt1}, RES_GT);
    chk("w1_cnt", cnt1, 1);
    chk("w1_busy_done", busy1, 0);
    tick();
    chk("w1_pulse", done1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_mag_compare.md
Name: serial_mag_compare

Overview:
Downstream consumer of the 1-bit `compare` cell's one-hot outputs. Each cycle the upstream cell compares one bit pair of operands A and B, MSB first, and drives F1 (A>B), F2 (A==B) and F3 (A<B). This block accumulates those per-bit verdicts over WIDTH bit-times into a WIDTH-bit magnitude result. It reports completion with a one-cycle done pulse and holds the result until the next start.

Parameters:
WIDTH, 8, operand width in bits (number of valid bit-times per comparison); legal range 1..32
CW, $clog2(WIDTH+1), width of the bit counter (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a new comparison; clears counter, result and error
bit_valid  in  1  f_gt/f_eq/f_lt carry a valid bit verdict this cycle
f_gt  in  1  upstream F1: current bit A>B
f_eq  in  1  upstream F2: current bit A==B
f_lt  in  1  upstream F3: current bit A<B
busy  out  1  high while in RUN
done  out  1  one-cycle pulse, comparison complete
res_gt  out  1  A>B (running while busy, final when done/idle)
res_eq  out  1  A==B
res_lt  out  1  A<B
err  out  1  sticky: non-one-hot verdict seen with bit_valid during this comparison
bit_cnt  out  CW  bits accepted so far

Behaviour:
- Single clock domain. Reset is synchronous and active-high: rst is sampled on the rising edge of clk.
- Reset values: state=IDLE; busy=0, done=0, res_gt=res_eq=res_lt=0 ("no result"), err=0, bit_cnt=0.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE: start=1 -> RUN. On that edge: bit_cnt=0, res_eq=1, res_gt=res_lt=0, err=0. bit_valid is ignored in IDLE, including when it arrives in the same cycle as start.
- RUN, start=1: restart. Apply the same clears as above and stay in RUN. Any bit_valid in that cycle is discarded.
- RUN, bit_valid=1, start=0: the bit is accepted and bit_cnt increments.
  - Decision rule (MSB first): if res_eq=1 and the verdict is exactly one-hot, load {res_gt,res_eq,res_lt} from {f_gt,f_eq,f_lt}.
  - If res_eq=0, the result is already decided; later bits are counted but do not change it.
  - Non-one-hot verdict (zero or multiple high): set err=1, treat the bit as equal (no result change), still count it.
- RUN, bit_valid=0: hold all state; gaps of any length are legal.
- Accepting the WIDTH-th bit moves the FSM to DONE. On the following cycle done=1, busy=0 and bit_cnt=WIDTH. Latency is therefore 1 cycle from the last accepted bit to done.
- DONE: lasts exactly one cycle, then returns to IDLE. start=1 while in DONE goes directly to RUN with clears; the done pulse still appears in that cycle.
- IDLE after DONE: res_*, err and bit_cnt hold their final values until the next start or rst.
- rst mid-comparison: immediate return to reset values; no done pulse is produced.
- busy = (state==RUN). done = (state==DONE).
- WIDTH=1: done follows the first accepted bit.

Decomposition:
- Shared package `compare_pkg`:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - result code constants RES_GT=3'b100, RES_EQ=3'b010, RES_LT=3'b001, RES_NONE=3'b000;
  - a one-hot check function used by this block and its bench.
- No sub-module is required. The bench instantiates `compare` upstream and this block downstream to form the full serial chain; the same bench also verifies this block standalone with forced f_* inputs.

Test Plan:
1. WIDTH=8, A=8'hA5, B=8'hA3 fed MSB-first, one bit per cycle -> after 8 accepts, done=1 for 1 cycle, res_gt=1, res_eq=0, res_lt=0, bit_cnt=8, err=0.
2. A=B=8'h3C -> res_eq=1, res_gt=res_lt=0 at done; result holds in IDLE for 10 idle cycles.
3. A=8'h00, B=8'h80 -> result becomes res_lt=1 after the first accept and stays res_lt=1 through bits 2..8, although later bits are equal.
4. Case 1 with bit_valid low for 3 cycles between every bit -> done appears only after the 8th valid bit, bit_cnt never advances during gaps, busy=1 throughout.
5. Abort cases:
   - start asserted after 4 bits of case 1 -> bit_cnt=0, res_eq=1, and 8 fresh bits are needed before done.
   - rst after 5 bits -> all outputs 0, state IDLE, no done pulse.
6. Forced f_gt=f_lt=1 on bit 3, all other bits equal -> err=1 at done and held, res_eq=1. The next start clears err to 0.
